// File: rtl/mult4_pkg.sv
// Shared definitions for the 4x4 shift-and-add multiplier.
package mult4_pkg;

  localparam int WIDTH  = 4;
  localparam int STEPS  = 4;
  localparam int PWIDTH = 8;

  // Counter value of the final RUN step.
  localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/RipAdder4.sv
// 4-bit ripple-carry adder stage built from full-adder cells.
module RipAdder4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CIN,
  output logic [3:0] SUM,
  output logic       COUT
);

  logic [4:0] carry_w;

  assign carry_w[0] = CIN;

  // Full-adder cells; carry ripples from bit 0 upward.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign SUM[i]       = A[i] ^ B[i] ^ carry_w[i];
    assign carry_w[i+1] = (A[i] & B[i]) | (carry_w[i] & (A[i] ^ B[i]));
  end

  assign COUT = carry_w[4];

endmodule

// File: rtl/mult4_shift_add.sv
// Sequential 4x4 unsigned shift-and-add multiplier around RipAdder4.
//
// Handshake: START is sampled only when BUSY=0 (IDLE or FIN). An accepted
// START latches A/B on that edge; BUSY is high for the four RUN steps and
// DONE pulses for exactly one cycle (the FIN cycle) when P has just been
// updated. START while BUSY=1 is ignored, never queued.
module mult4_shift_add
  import mult4_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [3:0]   A,
  input  logic [3:0]   B,
  output logic [7:0]   P,
  output logic         BUSY,
  output logic         DONE,
  output state_e       DBG_STATE
);

  state_e      state_q, state_d;
  logic [3:0]  m_q, m_d;
  logic [3:0]  acc_q, acc_d;
  logic [3:0]  q_q, q_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  p_q, p_d;

  logic [3:0]  sum_w;
  logic        cout_w;
  logic        step_c;
  logic [3:0]  step_s;
  logic [7:0]  step_w;

  // The only arithmetic in the datapath: ACC + M.
  RipAdder4 u_adder (
    .A    (acc_q),
    .B    (m_q),
    .CIN  (1'b0),
    .SUM  (sum_w),
    .COUT (cout_w)
  );

  // Next-state, step datapath and operand loading.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    // Add M only when the current multiplier bit is set.
    step_c = 1'b0;
    step_s = acc_q;
    if (q_q[0]) begin
      step_c = cout_w;
      step_s = sum_w;
    end
    // Right shift of {C, S, Q}; the dropped bit is Q[0].
    step_w = {step_c, step_s, q_q[3:1]};

    unique case (state_q)
      IDLE: begin
        if (START) begin
          m_d     = A;
          q_d     = B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = step_w[7:4];
        q_d   = step_w[3:0];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_STEP) begin
          p_d     = step_w;
          state_d = FIN;
        end
      end
      FIN: begin
        if (START) begin
          m_d     = A;
          q_d     = B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign P         = p_q;
  assign BUSY      = (state_q == RUN);
  assign DONE      = (state_q == FIN);
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_mult4_shift_add.sv
// Self-checking bench for mult4_shift_add against an arithmetic product model.
module tb_mult4_shift_add;
  import mult4_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  a;
  logic [3:0]  b;
  logic [7:0]  p;
  logic        busy;
  logic        done;
  state_e      dbg_state;

  int checks;
  int failures;
  logic [7:0] exp_q[$];

  mult4_shift_add dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .A         (a),
    .B         (b),
    .P         (p),
    .BUSY      (busy),
    .DONE      (done),
    .DBG_STATE (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present operands with START for one cycle, push model product.
  task automatic start_op(input logic [3:0] ta, input logic [3:0] tb);
    int prod;
    start = 1'b1;
    a     = ta;
    b     = tb;
    prod  = int'(ta) * int'(tb);
    exp_q.push_back(prod[7:0]);
    tick();
    start = 1'b0;
    a     = 4'($urandom_range(0, 15));
    b     = 4'($urandom_range(0, 15));
  endtask

  // Driver: run until DONE (bounded). lat counts cycles since START.
  task automatic wait_done(input int lat0, output int lat, output int busy_cnt,
                           output logic [7:0] p_seen, output bit p_held);
    logic [7:0] p_prev;
    lat      = lat0;
    busy_cnt = 0;
    p_held   = 1'b1;
    p_prev   = p;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      if (p !== p_prev) p_held = 1'b0;
      tick();
      lat++;
    end
    p_seen = p;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = 4'hF;
    b     = 4'hF;
    tick();
    tick();
    checks++;
    if (p !== 8'h00) begin failures++; $display("FAIL reset_p got=%h exp=00", p); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_flags busy=%b done=%b exp=0/0", busy, done);
    end
    checks++;
    if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    start = 1'b0;
    rst   = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_start_dropped busy=%b exp=0", busy); end
  endtask

  // One operation with full latency/busy/result/pulse checks.
  task automatic test_single(input logic [3:0] ta, input logic [3:0] tb, input string name);
    int lat, bcnt;
    logic [7:0] ps, expv;
    bit held;
    start_op(ta, tb);
    wait_done(1, lat, bcnt, ps, held);
    expv = exp_q.pop_front();
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL %s_latency got=%0d exp=5", name, lat); end
    checks++;
    if (bcnt !== 4) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=4", name, bcnt); end
    checks++;
    if (!held) begin failures++; $display("FAIL %s_p_hold got=changed exp=held", name); end
    checks++;
    if (ps !== expv) begin failures++; $display("FAIL %s_product got=%h exp=%h", name, ps, expv); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s_pulse done=%b busy=%b exp=0/0", name, done, busy);
    end
  endtask

  task automatic test_ignore_busy();
    int lat, bcnt;
    logic [7:0] ps, expv;
    bit held;
    start_op(4'h9, 4'h7);
    start = 1'b1;
    a     = 4'h3;
    b     = 4'h3;
    tick();
    start = 1'b0;
    wait_done(2, lat, bcnt, ps, held);
    expv = exp_q.pop_front();
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL ignore_latency got=%0d exp=5", lat); end
    checks++;
    if (ps !== expv) begin failures++; $display("FAIL ignore_product got=%h exp=%h", ps, expv); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic [7:0] ps, expv;
    bit held;
    start = 1'b1;
    a     = 4'h2;
    b     = 4'h3;
    exp_q.push_back(8'(2 * 3));
    tick();
    lat = 1;
    while (!done && lat < 20) begin tick(); lat++; end
    expv = exp_q.pop_front();
    checks++;
    if (lat !== 5 || p !== expv) begin
      failures++; $display("FAIL b2b_first lat=%0d p=%h exp=5/%h", lat, p, expv);
    end
    // FIN cycle: START still high, new operands presented.
    a = 4'h5;
    b = 4'h5;
    exp_q.push_back(8'(5 * 5));
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart busy=%b exp=1", busy); end
    wait_done(1, lat, bcnt, ps, held);
    expv = exp_q.pop_front();
    checks++;
    if (lat !== 5 || ps !== expv) begin
      failures++; $display("FAIL b2b_second lat=%0d p=%h exp=5/%h", lat, ps, expv);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    start_op(4'hF, 4'hF);
    void'(exp_q.pop_back());
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (p !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL midreset p=%h busy=%b done=%b exp=00/0/0", p, busy, done);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", pulses); end
  endtask

  task automatic test_random();
    int lat, bcnt, gap;
    logic [7:0] ps, expv;
    bit held;
    for (int n = 0; n < 25; n++) begin
      start_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      wait_done(1, lat, bcnt, ps, held);
      expv = exp_q.pop_front();
      checks++;
      if (lat !== 5 || ps !== expv || bcnt !== 4) begin
        failures++;
        $display("FAIL random_%0d lat=%0d busy=%0d p=%h exp=5/4/%h", n, lat, bcnt, ps, expv);
      end
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = 4'h0;
    b        = 4'h0;
    tick();
    test_reset();
    test_single(4'hD, 4'hB, "d_x_b");
    test_single(4'hF, 4'hF, "f_x_f");
    test_single(4'h0, 4'h9, "zero_a");
    test_single(4'h7, 4'h0, "zero_b");
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
